i2c_write_sequencer: RTL and testbench

- Avalon-MM slave I2C master that performs complete 3-byte I2C write transactions in hardware.
- Each transaction is {device address+W, register, data}, used for codec/video-decoder configuration.
- Replaces software bit-banging of the IIC GO/SCLK/SDAT PIO bits: the CPU loads one word, pulses GO and polls status.
- Sits between the Qsys interconnect and the board I2C pins; SDA is driven open-drain externally from i2c_sdat_oe.

---
 rtl/i2c_write_sequencer.sv | 119 +++++++++++
 tb/tb_i2c_write_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_sequencer.sv
// Avalon-MM I2C master: one GO runs START, three bytes {dev, reg, dat} with ACK checks, then STOP.
// Each SCL quarter lasts CLK_DIV clocks. A NACK skips any remaining bytes and goes straight to STOP.
module i2c_write_sequencer #(
  parameter int CLK_DIV = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        i2c_sclk,
  output logic        i2c_sdat_oe,
  input  logic        i2c_sdat_in,
  output logic        busy
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, BIT, STOP} state_t;

  state_t      state, state_nxt;
  logic [DW-1:0] div;
  logic [1:0]  quarter;
  logic [3:0]  bit_idx;
  logic [1:0]  byte_idx;
  logic [23:0] data, shreg;
  logic        ack_err, done;
  logic        wr, go, tick, ack_slot;
  logic        unused;

  assign unused   = &{1'b0, writedata[31:24]};
  assign wr       = chipselect && !write_n;
  assign busy     = (state != IDLE);
  assign go       = wr && (address == 2'd0) && writedata[0] && !busy;
  assign tick     = busy && (div == DIV_LAST);
  assign ack_slot = (bit_idx == 4'd8);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    i2c_sclk    = 1'b1;
    i2c_sdat_oe = 1'b0;
    case (state)
      IDLE: begin
        if (go) state_nxt = START;
      end
      START: begin
        i2c_sdat_oe = 1'b1;
        i2c_sclk    = (quarter == 2'd0);
        if (tick && quarter == 2'd1) state_nxt = BIT;
      end
      BIT: begin
        i2c_sclk    = (quarter == 2'd1) || (quarter == 2'd2);
        i2c_sdat_oe = !ack_slot && !shreg[23];
        // ack_err already reflects this slot's sample, taken at the end of q2
        if (tick && quarter == 2'd3 && ack_slot && (ack_err || byte_idx == 2'd2))
          state_nxt = STOP;
      end
      STOP: begin
        i2c_sclk    = (quarter != 2'd0);
        i2c_sdat_oe = (quarter < 2'd2);
        if (tick && quarter == 2'd3) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div      <= '0;
      quarter  <= 2'd0;
      bit_idx  <= 4'd0;
      byte_idx <= 2'd0;
      data     <= 24'd0;
      shreg    <= 24'd0;
      ack_err  <= 1'b0;
      done     <= 1'b0;
    end else begin
      div <= (!busy || div == DIV_LAST) ? '0 : div + 1'b1;
      if (wr && address == 2'd1 && !busy) data <= writedata[23:0];
      if (go) begin
        quarter  <= 2'd0;
        bit_idx  <= 4'd0;
        byte_idx <= 2'd0;
        shreg    <= data;
        ack_err  <= 1'b0;
        done     <= 1'b0;
      end else if (tick) begin
        quarter <= (state_nxt != state) ? 2'd0 : quarter + 2'd1;
        if (state == BIT && quarter == 2'd2 && ack_slot && i2c_sdat_in) ack_err <= 1'b1;
        if (state == BIT && quarter == 2'd3) begin
          if (ack_slot) begin
            bit_idx  <= 4'd0;
            byte_idx <= byte_idx + 2'd1;
          end else begin
            bit_idx <= bit_idx + 4'd1;
            shreg   <= {shreg[22:0], 1'b0};
          end
        end
        if (state == STOP && quarter == 2'd3) done <= 1'b1;
      end
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd1:    readdata = {8'h00, data};
      2'd2:    readdata = {29'd0, done, ack_err, busy};
      default: readdata = 32'd0;
    endcase
  end
endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Bench for i2c_write_sequencer: per-cycle waveform model of SCL/SDA/busy/readdata,
// plus an I2C slave that ACKs or NACKs and decodes the SDA bits seen on SCL rising edges.
module tb_i2c_write_sequencer;
  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        i2c_sclk;
  logic        i2c_sdat_oe;
  logic        i2c_sdat_in;
  logic        busy;
  logic        pull = 1'b0;

  int checks = 0, errors = 0;
  int cyc = 0, go_cyc = 0;
  int nack_byte = 3;
  bit chk_en = 0;

  i2c_write_sequencer #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .i2c_sclk(i2c_sclk), .i2c_sdat_oe(i2c_sdat_oe), .i2c_sdat_in(i2c_sdat_in), .busy(busy)
  );

  assign i2c_sdat_in = !(i2c_sdat_oe || pull);

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, want, $time);
    end
  endtask

  // Waveform model: one entry per clock of expected {scl, oe, ack_err}
  typedef struct packed {logic scl; logic oe; logic err;} exp_t;
  exp_t exp_q[$];
  logic [23:0] m_data;
  logic m_err, m_done;

  task automatic add_q(input logic s, input logic o, input logic e);
    exp_t x;
    x.scl = s; x.oe = o; x.err = e;
    repeat (CLK_DIV) exp_q.push_back(x);
  endtask

  task automatic push_txn(input logic [23:0] d, input int nb);
    logic e;
    logic [7:0] by;
    e = 1'b0;
    add_q(1, 1, 0); add_q(0, 1, 0);
    for (int b = 0; b < 3; b++) begin
      by = d[23 - 8*b -: 8];
      for (int i = 7; i >= 0; i--) begin
        add_q(0, !by[i], 0); add_q(1, !by[i], 0); add_q(1, !by[i], 0); add_q(0, !by[i], 0);
      end
      add_q(0, 0, 0); add_q(1, 0, 0); add_q(1, 0, 0);
      if (b == nb) e = 1'b1;
      add_q(0, 0, e);
      if (e) break;
    end
    add_q(0, 1, e); add_q(1, 1, e); add_q(1, 0, e); add_q(1, 0, e);
  endtask

  always @(posedge clk) begin : model
    logic was_busy;
    was_busy = (exp_q.size() != 0);
    if (was_busy) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) m_done = 1'b1;
      else                   m_err  = exp_q[0].err;
    end
    if (reset) begin
      exp_q.delete();
      m_data = 24'd0; m_err = 1'b0; m_done = 1'b0;
    end else if (chipselect && !write_n && !was_busy) begin
      if (address == 2'd1) m_data = writedata[23:0];
      else if (address == 2'd0 && writedata[0]) begin
        m_err = 1'b0; m_done = 1'b0;
        push_txn(m_data, nack_byte);
      end
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      exp_t w;
      logic b;
      logic [31:0] rd_w;
      b = (exp_q.size() != 0);
      if (b) w = exp_q[0];
      else begin w.scl = 1'b1; w.oe = 1'b0; w.err = 1'b0; end
      case (address)
        2'd1:    rd_w = {8'h00, m_data};
        2'd2:    rd_w = {29'd0, m_done, m_err, b};
        default: rd_w = 32'd0;
      endcase
      chk("scl", {31'd0, i2c_sclk}, {31'd0, w.scl});
      chk("oe", {31'd0, i2c_sdat_oe}, {31'd0, w.oe});
      chk("busy", {31'd0, busy}, {31'd0, b});
      chk("readdata", readdata, rd_w);
    end
  end

  // Slave: START resets the byte framing; pulls SDA from the 8th to the 9th SCL fall of each byte
  bit bits_q[$];
  int fcnt = 0;
  logic pscl = 1'b1, psda = 1'b1;

  always @(negedge clk) begin : slave
    logic scl, sda;
    scl = i2c_sclk;
    sda = i2c_sdat_in;
    if (reset) begin
      pull = 1'b0; fcnt = 0;
    end else if (pscl && scl && psda && !sda) begin
      fcnt = 0; pull = 1'b0; bits_q.delete();
    end else if (!pscl && scl) begin
      bits_q.push_back(sda);
    end else if (pscl && !scl) begin
      fcnt++;
      pull = (fcnt % 9 == 0) && ((fcnt / 9 - 1) != nack_byte);
    end
    pscl = scl;
    psda = sda;
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic go_now();
    address = 2'd0; writedata = 32'd1; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
    go_cyc = cyc;
  endtask

  task automatic go();
    @(posedge clk); #1;
    go_now();
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] want, input string name);
    @(posedge clk); #1;
    address = a;
    #1 chk(name, readdata, want);
  endtask

  task automatic wait_idle(input string name, input int want_cycles);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) $display("FAIL %s: timeout, busy never fell", name);
    chk(name, cyc - go_cyc, want_cycles);
  endtask

  task automatic chk_stream(input string name, input int nbits, input logic [31:0] want);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < nbits && i < bits_q.size(); i++) v = {v[30:0], bits_q[i]};
    chk({name, "_len"}, bits_q.size(), nbits + 1);
    chk(name, v, want);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    reset = 1'b0;
    chk("rst_sclk", {31'd0, i2c_sclk}, 32'd1);
    chk("rst_oe", {31'd0, i2c_sdat_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rd(2'd1, 32'd0, "rst_data");

    // Register access
    wr(2'd1, 32'hAB341E00);
    rd(2'd1, 32'h00341E00, "data_rb");
    rd(2'd2, 32'd0, "status_idle");
    rd(2'd3, 32'd0, "addr3");
    rd(2'd0, 32'd0, "ctrl_rd");

    // Full ACKed write
    nack_byte = 3;
    go();
    chk("go_busy", {31'd0, busy}, 32'd1);
    wait_idle("ack_cycles", 456);
    rd(2'd2, 32'h4, "ack_status");
    chk_stream("ack_stream", 27, 32'(27'b001101000_000111100_000000000));

    // NACK on address byte
    nack_byte = 0;
    go();
    wait_idle("nack_cycles", 168);
    rd(2'd2, 32'h6, "nack_status");
    chk_stream("nack_stream", 9, 32'(9'b001101001));

    // Writes while busy are ignored
    nack_byte = 3;
    go();
    repeat (50) @(posedge clk);
    wr(2'd1, 32'hFFFFFFFF);
    wr(2'd0, 32'd1);
    rd(2'd1, 32'h00341E00, "wwb_data_rb");
    wait_idle("wwb_cycles", 456);
    rd(2'd2, 32'h4, "wwb_status");
    chk_stream("wwb_stream", 27, 32'(27'b001101000_000111100_000000000));
    repeat (30) @(posedge clk);
    chk("wwb_single", {31'd0, busy}, 32'd0);

    // Reset during bit 10
    go();
    repeat (169) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_sclk", {31'd0, i2c_sclk}, 32'd1);
    chk("mid_rst_oe", {31'd0, i2c_sdat_oe}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    rd(2'd2, 32'd0, "mid_rst_status");
    rd(2'd1, 32'd0, "mid_rst_data");
    wr(2'd1, 32'h005A81C3);
    go();
    wait_idle("post_rst_cycles", 456);
    rd(2'd2, 32'h4, "post_rst_status");
    chk_stream("post_rst_stream", 27, 32'(27'b010110100_100000010_110000110));

    // Back-to-back: GO one cycle early is dropped, GO on the first idle cycle starts anew
    go();
    repeat (455) @(posedge clk);
    #1 go_now();
    chk("b2b_early_busy", {31'd0, busy}, 32'd0);
    address = 2'd2;
    #1 chk("b2b_early_status", readdata, 32'h4);
    go_now();
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_start_oe", {31'd0, i2c_sdat_oe}, 32'd1);
    address = 2'd2;
    #1 chk("b2b_status", readdata, 32'h1);
    wait_idle("b2b_cycles", 456);
    rd(2'd2, 32'h4, "b2b_final_status");

    repeat (20) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
